// File: rtl/popcnt_window_pkg.sv
// Shared constants and width helpers for the popcnt_window block.
//   CHUNK_W          : width of one popcnt6 input chunk
//   countWidth       : width needed for the total of one window
//   sampleCountWidth : width needed for the popcount of one sample
package popcnt_window_pkg;

    localparam int unsigned CHUNK_W = 6;

    function automatic int unsigned countWidth(int unsigned n_chunks,
                                               int unsigned window_length);
        return $clog2(CHUNK_W * n_chunks * window_length + 1);
    endfunction

    function automatic int unsigned sampleCountWidth(int unsigned n_chunks);
        return $clog2(CHUNK_W * n_chunks + 1);
    endfunction

endpackage

// File: rtl/popcnt6.sv
// Population count of a 6-bit value.
//   ABSTRACT_MODEL=0 : two full adders followed by a small carry-merge stage
//   ABSTRACT_MODEL=1 : behavioural bit-by-bit count, used as a reference
// Ports:
//   x  : 6-bit input value
//   pc : number of set bits in x (0..6)
module popcnt6 #(
    parameter bit ABSTRACT_MODEL = 1'b0
) (
    input  logic [5:0] x,
    output logic [2:0] pc
);

    if (ABSTRACT_MODEL) begin : g_abstract
        always_comb begin
            pc = '0;
            for (int i = 0; i < 6; i++) begin
                pc = pc + 3'(x[i]);
            end
        end
    end else begin : g_struct
        logic s_lo, c_lo, s_hi, c_hi, c_mid;

        // Each half reduces three bits to a sum/carry pair.
        assign s_lo  = x[0] ^ x[1] ^ x[2];
        assign c_lo  = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
        assign s_hi  = x[3] ^ x[4] ^ x[5];
        assign c_hi  = (x[3] & x[4]) | (x[3] & x[5]) | (x[4] & x[5]);
        assign c_mid = s_lo & s_hi;

        // Weight-2 bits (c_lo, c_hi, c_mid) are themselves full-added.
        assign pc[0] = s_lo ^ s_hi;
        assign pc[1] = c_lo ^ c_hi ^ c_mid;
        assign pc[2] = (c_lo & c_hi) | (c_lo & c_mid) | (c_hi & c_mid);
    end

endmodule

// File: rtl/popcnt_sum.sv
// Combinational popcount of an N_CHUNKS*6-bit sample: one popcnt6 per chunk,
// with the chunk counts summed.
// Ports:
//   x  : sample data, 6*N_CHUNKS bits
//   pc : popcount of x, sampleCountWidth(N_CHUNKS) bits
module popcnt_sum
    import popcnt_window_pkg::*;
#(
    parameter int unsigned N_CHUNKS       = 2,
    parameter bit          ABSTRACT_MODEL = 1'b0,
    localparam int unsigned PC_W          = sampleCountWidth(N_CHUNKS)
) (
    input  logic [CHUNK_W*N_CHUNKS-1:0] x,
    output logic [PC_W-1:0]             pc
);

    logic [2:0] chunk_pc [N_CHUNKS];

    for (genvar g = 0; g < N_CHUNKS; g++) begin : g_chunk
        popcnt6 #(
            .ABSTRACT_MODEL(ABSTRACT_MODEL)
        ) u_popcnt6 (
            .x (x[g*CHUNK_W +: CHUNK_W]),
            .pc(chunk_pc[g])
        );
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < N_CHUNKS; i++) begin
            pc = pc + PC_W'(chunk_pc[i]);
        end
    end

endmodule

// File: rtl/popcnt_window.sv
// Windowed popcount accumulator. Sums the popcount of WINDOW_LENGTH accepted
// samples and presents the total on a registered valid/ready output.
// Optional feature macro: POPCNT_WINDOW_PEAK_EN adds o_peak, the largest
// per-sample popcount seen in the window, loaded and held with o_count.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_cg             : clock gate; low freezes all state and handshakes
//   i_clear          : restart the window, dropping the partial sum
//   i_x, i_valid     : sample input; o_ready is the sample-side ready
//   o_count, o_valid : window total; i_ready is the result-side ready
//   o_peak           : (POPCNT_WINDOW_PEAK_EN only) window peak popcount
module popcnt_window
    import popcnt_window_pkg::*;
#(
    parameter int unsigned N_CHUNKS      = 2,
    parameter int unsigned WINDOW_LENGTH = 16,
    localparam int unsigned DATA_W       = CHUNK_W * N_CHUNKS,
    localparam int unsigned PC_W         = sampleCountWidth(N_CHUNKS),
    localparam int unsigned COUNT_W      = countWidth(N_CHUNKS, WINDOW_LENGTH),
    localparam int unsigned CNT_W        = $clog2(WINDOW_LENGTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cg,
    input  logic               i_clear,
    input  logic [DATA_W-1:0]  i_x,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_valid,
`ifdef POPCNT_WINDOW_PEAK_EN
    output logic [PC_W-1:0]    o_peak,
`endif
    input  logic               i_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_LENGTH - 1);

    logic [PC_W-1:0]    pc;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               valid_q, valid_d;
    logic [COUNT_W-1:0] acc_sum;
    logic               last, in_fire, out_fire;

    popcnt_sum #(
        .N_CHUNKS      (N_CHUNKS),
        .ABSTRACT_MODEL(1'b0)
    ) u_popcnt_sum (
        .x (i_x),
        .pc(pc)
    );

    assign last     = (cnt_q == LAST_CNT);
    // Only the window-completing sample can stall, and only behind an
    // unconsumed result.
    assign o_ready  = !i_rst && (!last || !valid_q || i_ready);
    assign in_fire  = i_valid && o_ready && i_cg;
    assign out_fire = valid_q && i_ready && i_cg;
    assign acc_sum  = acc_q + COUNT_W'(pc);

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        count_d = count_q;
        valid_d = valid_q;
        if (out_fire) begin
            valid_d = 1'b0;
        end
        if (i_cg && i_clear) begin
            // Clear wins; a sample handshaking this cycle is dropped.
            acc_d = '0;
            cnt_d = '0;
        end else if (in_fire) begin
            if (last) begin
                count_d = acc_sum;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign o_count = count_q;
    assign o_valid = valid_q;

`ifdef POPCNT_WINDOW_PEAK_EN
    logic [PC_W-1:0] win_peak_q, win_peak_d;
    logic [PC_W-1:0] peak_q, peak_d;
    logic [PC_W-1:0] peak_max;

    assign peak_max = (pc > win_peak_q) ? pc : win_peak_q;

    always_comb begin
        win_peak_d = win_peak_q;
        peak_d     = peak_q;
        if (i_cg && i_clear) begin
            win_peak_d = '0;
        end else if (in_fire) begin
            if (last) begin
                peak_d     = peak_max;
                win_peak_d = '0;
            end else begin
                win_peak_d = peak_max;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            win_peak_q <= '0;
            peak_q     <= '0;
        end else begin
            win_peak_q <= win_peak_d;
            peak_q     <= peak_d;
        end
    end

    assign o_peak = peak_q;
`endif

endmodule

// File: tb/tb_popcnt_window.sv
// Self-checking bench for popcnt_window (N_CHUNKS=2, WINDOW_LENGTH=4).
// A window model built from a queue of per-sample popcounts is checked
// against the DUT every cycle; directed windows pin literal totals.
module tb_popcnt_window;

    localparam int unsigned WL = 4;

    logic        clk = 1'b0;
    logic        i_rst, i_cg, i_clear, i_valid, i_ready;
    logic [11:0] i_x;
    logic        o_ready, o_valid;
    logic [5:0]  o_count;
    logic [3:0]  ref_pc;
`ifdef POPCNT_WINDOW_PEAK_EN
    logic [3:0]  o_peak;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: result register and the popcounts of the open window.
    bit m_valid = 1'b0;
    int m_count = 0;
    int m_peak  = 0;
    int win[$];

    always #5 clk = ~clk;

    popcnt_window #(
        .N_CHUNKS     (2),
        .WINDOW_LENGTH(WL)
    ) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_cg   (i_cg),
        .i_clear(i_clear),
        .i_x    (i_x),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_count(o_count),
        .o_valid(o_valid),
`ifdef POPCNT_WINDOW_PEAK_EN
        .o_peak (o_peak),
`endif
        .i_ready(i_ready)
    );

    popcnt_sum #(
        .N_CHUNKS      (2),
        .ABSTRACT_MODEL(1'b1)
    ) u_ref (
        .x (i_x),
        .pc(ref_pc)
    );

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        n_checks++;
        if (actual !== 32'(expected)) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change #1 after posedge, so at negedge they are exactly what the
    // next posedge samples; outputs have settled from the previous posedge.
    always @(negedge clk) begin
        bit exp_ready;
        int sum;
        int pk;
        exp_ready = !i_rst && !((win.size() == WL - 1) && m_valid && !i_ready);
        check("cyc_o_ready", 32'(o_ready), int'(exp_ready));
        check("cyc_o_valid", 32'(o_valid), int'(m_valid));
        check("cyc_o_count", 32'(o_count), m_count);
`ifdef POPCNT_WINDOW_PEAK_EN
        check("cyc_o_peak", 32'(o_peak), m_peak);
`endif
        if (i_rst) begin
            m_valid = 1'b0;
            m_count = 0;
            m_peak  = 0;
            win.delete();
        end else if (i_cg) begin
            if (m_valid && i_ready) m_valid = 1'b0;
            if (i_clear) begin
                win.delete();
            end else if (i_valid && exp_ready) begin
                win.push_back(int'(ref_pc));
                if (win.size() == WL) begin
                    sum = 0;
                    pk  = 0;
                    foreach (win[k]) begin
                        sum += win[k];
                        if (win[k] > pk) pk = win[k];
                    end
                    m_count = sum;
                    m_peak  = pk;
                    m_valid = 1'b1;
                    win.delete();
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Checks DUT and model against a hand-computed result.
    task automatic chk_res(input string name, input int valid, input int count, input int peak);
        check({name, "_valid"}, 32'(o_valid), valid);
        check({name, "_count"}, 32'(o_count), count);
        check({name, "_model"}, 32'(m_count), count);
`ifdef POPCNT_WINDOW_PEAK_EN
        check({name, "_peak"}, 32'(o_peak), peak);
`else
        if (peak < 0) $display("negative peak %0d", peak);
`endif
    endtask

    initial begin
        i_rst = 1'b1; i_cg = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_x = '0;
        cyc();
        cyc();
        check("rst_ready", 32'(o_ready), 0);
        chk_res("rst", 0, 0, 0);
        i_rst = 1'b0;

        // Four all-ones samples: 4 x 12 = 48.
        i_ready = 1'b1; i_valid = 1'b1; i_x = 12'hFFF;
        #1 check("ref_fff", 32'(ref_pc), 12);
        repeat (4) cyc();
        chk_res("t1", 1, 48, 12);
        i_valid = 1'b0;
        cyc();
        check("t1_pulse", 32'(o_valid), 0);

        // 1 + 2 + 0 + 4 = 7, then an all-zero window.
        i_valid = 1'b1;
        i_x = 12'h001; cyc();
        i_x = 12'h003; cyc();
        i_x = 12'h000; cyc();
        i_x = 12'h807;
        #1 check("ref_807", 32'(ref_pc), 4);
        cyc();
        chk_res("t2a", 1, 7, 4);
        i_x = 12'h000;
        repeat (3) cyc();
        check("t2_gap", 32'(o_valid), 0);
        cyc();
        chk_res("t2b", 1, 0, 0);
        i_valid = 1'b0;
        cyc();

        // Held result stalls only the window-completing sample.
        i_ready = 1'b0; i_valid = 1'b1; i_x = 12'hFFF;
        repeat (4) cyc();
        chk_res("t3_held", 1, 48, 12);
        i_x = 12'h0FF;
        repeat (3) cyc();
        check("t3_stall_ready", 32'(o_ready), 0);
        repeat (2) cyc();
        chk_res("t3_stalled", 1, 48, 12);
        check("t3_still_stalled", 32'(o_ready), 0);
        i_ready = 1'b1;
        #1 check("t3_release_ready", 32'(o_ready), 1);
        cyc();
        chk_res("t3_b2b", 1, 32, 8);
        i_valid = 1'b0;
        cyc();
        check("t3_drain", 32'(o_valid), 0);

        // Clear with a concurrent sample drops both partial sum and sample.
        i_valid = 1'b1; i_x = 12'hFFF;
        repeat (2) cyc();
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0; i_x = 12'h00F;
        repeat (3) cyc();
        check("t4_early", 32'(o_valid), 0);
        cyc();
        chk_res("t4", 1, 16, 4);
        i_valid = 1'b0;
        cyc();

        // Reset mid-window with a held result.
        i_ready = 1'b0; i_valid = 1'b1; i_x = 12'hFFF;
        repeat (6) cyc();
        i_rst = 1'b1; i_valid = 1'b0;
        #1 check("t5_rst_ready", 32'(o_ready), 0);
        cyc();
        chk_res("t5_rst", 0, 0, 0);
        i_rst = 1'b0; i_ready = 1'b1; i_valid = 1'b1; i_x = 12'h0F0;
        repeat (4) cyc();
        chk_res("t5", 1, 16, 4);
        i_valid = 1'b0;
        cyc();

        // Randomised traffic against the per-cycle model.
        for (int c = 0; c < 10000; c++) begin
            i_x     = 12'($urandom);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 9) < 7);
            i_cg    = ($urandom_range(0, 9) != 0);
            i_clear = ($urandom_range(0, 49) == 0);
            i_rst   = ($urandom_range(0, 499) == 0);
            cyc();
        end
        i_rst = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_cg = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
